// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave responder.
// Defining SPI_SLAVE_LSB_FIRST_EN switches both shift directions to LSB first.
`timescale 1ns/1ps
package spi_slave_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int FRAME_BITS = 8;
  localparam logic [FRAME_BITS-1:0] TX_FILL = 8'hFF;

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// Receive FIFO: power-of-two depth, wrap-bit pointers, and push/pop in the same
// cycle are both honoured (a full FIFO accepts a push when it is also popped).
`timescale 1ns/1ps
module spi_slave_rx_fifo
  import spi_slave_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [FRAME_BITS-1:0] push_data,
  input  logic                  pop,
  output logic [FRAME_BITS-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [FRAME_BITS-1:0] mem_q [RX_DEPTH];
  logic [FRAME_BITS-1:0] mem_d [RX_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-0 slave with an RX FIFO and a one-byte TX holding register.
// Optional macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting in both directions.
`timescale 1ns/1ps
module spi_slave_resp
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RX_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
  function automatic logic [FRAME_BITS-1:0] rx_shift_in(input logic [FRAME_BITS-1:0] v,
                                                       input logic b);
    return {b, v[FRAME_BITS-1:1]};
  endfunction
  function automatic logic [FRAME_BITS-1:0] tx_shift_out(input logic [FRAME_BITS-1:0] v);
    return {1'b0, v[FRAME_BITS-1:1]};
  endfunction
`else
  localparam int OUT_BIT = FRAME_BITS - 1;
  function automatic logic [FRAME_BITS-1:0] rx_shift_in(input logic [FRAME_BITS-1:0] v,
                                                       input logic b);
    return {v[FRAME_BITS-2:0], b};
  endfunction
  function automatic logic [FRAME_BITS-1:0] tx_shift_out(input logic [FRAME_BITS-1:0] v);
    return {v[FRAME_BITS-2:0], 1'b0};
  endfunction
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q, armed_q, armed_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0]  hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   rx_overflow_q;
  logic                   load, push, fifo_full, fifo_empty, fifo_overflow;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A fall only counts once cs_n has been seen high since reset, so a frame
  // interrupted by reset is never resumed mid-way.
  assign sclk_rise = !sclk_prev_q && sclk_s;
  assign sclk_fall = sclk_prev_q && !sclk_s;
  assign cs_fall   = armed_q && cs_prev_q && !cs_s;
  assign cs_rise   = !cs_prev_q && cs_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    armed_d     = armed_q | cs_s;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    tx_underrun_d = 1'b0;
    load          = 1'b0;
    push          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_shift_in(rx_shift_q, mosi_s);
          bit_cnt_d  = bit_cnt_q + 1'b1;
          push       = (bit_cnt_q == LAST_BIT);
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            load = 1'b1;
          end else begin
            tx_shift_d = tx_shift_out(tx_shift_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty holding register at load time sends the fill byte instead.
    if (load) begin
      hold_valid_d = 1'b0;
      if (hold_valid_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d    = TX_FILL;
        tx_underrun_d = 1'b1;
      end
    end

    if (tx_valid && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overflow_q <= fifo_overflow;
    end
  end

  spi_slave_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rx_shift_d),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  assign miso_oe     = !cs_s;
  assign busy        = !cs_s;
  assign miso        = (miso_oe && state_q == SHIFT) ? tx_shift_q[OUT_BIT] : 1'b0;
  assign rx_valid    = !fifo_empty;
  assign tx_ready    = !hold_valid_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Self-checking bench for spi_slave_resp: a bit-banged mode-0 master plus a
// queue-based model of the RX FIFO and TX holding register.
`timescale 1ns/1ps
module tb_spi_slave_resp;
  import spi_slave_pkg::*;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int H     = 10;

  logic       clock = 1'b0;
  logic       reset, sclk, cs_n, mosi, miso, miso_oe;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, rx_overflow, tx_underrun, busy;

  int         checks = 0;
  int         failures = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] send_q[$];
  logic [7:0] tx_plan[$];
  logic [7:0] got_q[$];
  logic       hold_v;
  logic [7:0] hold_b;
  logic [7:0] last_pop;
  int         exp_ovf, exp_und, ovf_obs, und_obs, pop_cnt, und_start;
  logic       rx_rand_en, rx_ready_man;

  always #5 clock = ~clock;

  spi_slave_resp #(
    .SYNC_STAGES (SYNC),
    .RX_DEPTH    (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_overflow (rx_overflow),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  // Bit ordering seen by the master on the wire.
  function automatic logic bit_of(input logic [7:0] b, input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return b[k];
`else
    return b[7-k];
`endif
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {b, v[7:1]};
`else
    return {v[6:0], b};
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Model: every load consumes the held byte or falls back to the fill byte.
  task automatic model_load(output logic [7:0] b);
    if (hold_v) begin
      b      = hold_b;
      hold_v = 1'b0;
    end else begin
      b = 8'hFF;
      exp_und++;
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_rx.size() >= DEPTH) exp_ovf++;
    else exp_rx.push_back(b);
  endtask

  task automatic offer_if_planned();
    logic [7:0] b;
    if (!hold_v && tx_plan.size() > 0) begin
      b = tx_plan.pop_front();
      @(posedge clock);
      #1;
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clock);
      checkOutput("tx_ready_when_empty", 32'(tx_ready), 32'd1);
      if (tx_ready) begin
        hold_b = b;
        hold_v = 1'b1;
      end
      @(posedge clock);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  // Mode-0 master: drives nbits from send_q, samples miso on each rising edge.
  task automatic applyStimulus(input int nbits, input bit end_frame);
    logic [7:0] cur_tx, sb, mo;
    int und0, exp0;
    und0   = und_obs;
    exp0   = exp_und;
    sb     = 8'h00;
    mo     = 8'h00;
    cs_n   = 1'b0;
    model_load(cur_tx);
    for (int i = 0; i < nbits; i++) begin
      int bp;
      bp = i % 8;
      if (bp == 0) sb = (send_q.size() > 0) ? send_q.pop_front() : 8'h00;
      mosi = bit_of(sb, bp);
      if (bp == 0) begin
        wait_clk(5);
        if (i == 0) begin
          und_start = und_obs - und0;
          checkOutput("underrun_at_cs_fall", 32'(und_start), 32'(exp_und - exp0));
        end
        offer_if_planned();
        wait_clk(3);
      end else begin
        wait_clk(H);
      end
      sclk = 1'b1;
      mo   = shift_in(mo, miso);
      if (bp == 7) begin
        model_push(sb);
        checkOutput("miso_byte", 32'(mo), 32'(cur_tx));
        got_q.push_back(mo);
      end
      wait_clk(H);
      sclk = 1'b0;
      if (bp == 7) model_load(cur_tx);
    end
    if (end_frame) begin
      wait_clk(H);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(2 * H);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_rx.size() > 0 && n < budget) begin
      wait_clk(1);
      n++;
    end
    if (exp_rx.size() > 0) checkOutput("drain_timeout", 32'(exp_rx.size()), 32'd0);
    wait_clk(2);
    checkOutput("rx_valid_after_drain", 32'(rx_valid), 32'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_miso", 32'(miso), 32'd0);
    checkOutput("rst_miso_oe", 32'(miso_oe), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    checkOutput("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
  endtask

  // Per-cycle compare against the model, sampled away from the active edge.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (!miso_oe) checkOutput("miso_when_disabled", 32'(miso), 32'd0);
        checkOutput("busy_tracks_oe", 32'(busy), 32'(miso_oe));
        if (rx_valid && exp_rx.size() == 0) checkOutput("rx_valid_spurious", 32'(rx_valid), 32'd0);
        if (rx_valid && rx_ready && exp_rx.size() > 0) begin
          e = exp_rx.pop_front();
          checkOutput("rx_pop_data", 32'(rx_data), 32'(e));
          last_pop = rx_data;
          pop_cnt++;
        end
        if (rx_overflow) ovf_obs++;
        if (tx_underrun) und_obs++;
      end
    end
  endtask

  task automatic rx_driver();
    forever begin
      @(posedge clock);
      #1;
      rx_ready = rx_rand_en ? 1'($urandom_range(0, 1)) : rx_ready_man;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0, o0, n, nb;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    rx_rand_en = 1'b0; rx_ready_man = 1'b0; hold_v = 1'b0; hold_b = 8'h00;
    last_pop = 8'h00; exp_ovf = 0; exp_und = 0; ovf_obs = 0; und_obs = 0;
    pop_cnt = 0; und_start = 0;
    fork
      monitor();
      rx_driver();
    join_none
    wait_clk(3);
    checkReset();
    reset = 1'b0;
    wait_clk(4);

    // 0xA5 in, preloaded 0x3C out.
    tx_plan = '{8'h3C};
    offer_if_planned();
    got_q.delete();
    send_q = '{8'hA5};
    applyStimulus(8, 1);
    checkOutput("t1_miso_3c", 32'(got_q[0]), 32'h3C);
    checkOutput("t1_rx_valid", 32'(rx_valid), 32'd1);
    p0 = pop_cnt;
    rx_ready_man = 1'b1;
    drain(50);
    rx_ready_man = 1'b0;
    checkOutput("t1_pop_count", 32'(pop_cnt - p0), 32'd1);
    checkOutput("t1_rx_a5", 32'(last_pop), 32'hA5);

    // No TX data: fill byte and one underrun at the frame start.
    got_q.delete();
    send_q = '{8'hC3};
    applyStimulus(8, 1);
    checkOutput("t2_miso_ff", 32'(got_q[0]), 32'hFF);
    checkOutput("t2_underrun_once", 32'(und_start), 32'd1);
    rx_ready_man = 1'b1;
    drain(50);
    rx_ready_man = 1'b0;

    // Five bytes into a four-entry FIFO with no consumer.
    send_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    o0 = ovf_obs;
    applyStimulus(40, 1);
    checkOutput("t3_overflow_pulses", 32'(ovf_obs - o0), 32'd1);
    checkOutput("t3_model_depth", 32'(exp_rx.size()), 32'd4);
    for (int k = 0; k < 4; k++) checkOutput("t3_model_entry", 32'(exp_rx[k]), 32'(k + 1));
    p0 = pop_cnt;
    rx_ready_man = 1'b1;
    drain(50);
    rx_ready_man = 1'b0;
    checkOutput("t3_pop_count", 32'(pop_cnt - p0), 32'd4);
    checkOutput("t3_last_pop", 32'(last_pop), 32'h04);

    // Frame aborted after 5 bits, then a full 0x81.
    send_q = '{8'hB7};
    applyStimulus(5, 1);
    checkOutput("t4_no_partial_push", 32'(rx_valid), 32'd0);
    send_q = '{8'h81};
    p0 = pop_cnt;
    applyStimulus(8, 1);
    rx_ready_man = 1'b1;
    drain(50);
    rx_ready_man = 1'b0;
    checkOutput("t4_pop_count", 32'(pop_cnt - p0), 32'd1);
    checkOutput("t4_rx_81", 32'(last_pop), 32'h81);

    // Back-to-back bytes, second TX byte supplied during the first.
    tx_plan = '{8'h11};
    offer_if_planned();
    tx_plan = '{8'h22};
    got_q.delete();
    send_q = '{8'h3E, 8'h4D};
    applyStimulus(16, 1);
    checkOutput("t5_miso_11", 32'(got_q[0]), 32'h11);
    checkOutput("t5_miso_22", 32'(got_q[1]), 32'h22);
    rx_ready_man = 1'b1;
    drain(80);
    rx_ready_man = 1'b0;

    // sclk activity while deselected must not shift anything in.
    for (int k = 0; k < 16; k++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      wait_clk(H);
    end
    sclk = 1'b0;
    wait_clk(H);
    checkOutput("t6_idle_sclk", 32'(rx_valid), 32'd0);

    // Reset three bits into a frame, then a clean 0x5A.
    send_q = '{8'hE7};
    applyStimulus(3, 0);
    reset = 1'b1;
    exp_rx.delete();
    hold_v = 1'b0;
    wait_clk(1);
    checkReset();
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    send_q = '{8'h5A};
    applyStimulus(8, 1);
    rx_ready_man = 1'b1;
    drain(50);
    rx_ready_man = 1'b0;
    checkOutput("t7_rx_5a", 32'(last_pop), 32'h5A);

    // Randomized frames with a random consumer and random TX supply.
    rx_rand_en = 1'b1;
    for (int f = 0; f < 15; f++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) send_q.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        tx_plan.push_back(8'($urandom_range(0, 255)));
        offer_if_planned();
      end
      for (int k = 0; k < nb; k++)
        if ($urandom_range(0, 2) != 0) tx_plan.push_back(8'($urandom_range(0, 255)));
      n = 8 * nb;
      if ($urandom_range(0, 3) == 0) n = n - $urandom_range(1, 7);
      applyStimulus(n, 1);
      tx_plan.delete();
      send_q.delete();
      drain(400);
    end
    rx_rand_en = 1'b0;

    wait_clk(20);
    checkOutput("total_overflow", 32'(ovf_obs), 32'(exp_ovf));
    checkOutput("total_underrun", 32'(und_obs), 32'(exp_und));
    checkOutput("rx_model_empty", 32'(exp_rx.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_resp.md
SPI_SLAVE_RESP -- requirements
Module: spi_slave_resp

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs_n/mosi (min 2).
REQ-002 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries (power of two, min 2).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clock  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sclk  in  1  SPI serial clock from the master, asynchronous to clock.
REQ-006 cs_n  in  1  SPI chip select, active low, asynchronous.
REQ-007 mosi  in  1  master-out serial data.
REQ-008 miso  out  1  slave-out serial data.
REQ-009 miso_oe  out  1  MISO output enable, high while selected.
REQ-010 rx_data  out  8  oldest received byte.
REQ-011 rx_valid  out  1  RX FIFO not empty.
REQ-012 rx_ready  in  1  consumer pops rx_data when rx_valid && rx_ready.
REQ-013 tx_data  in  8  next response byte.
REQ-014 tx_valid  in  1  tx_data offered.
REQ-015 tx_ready  out  1  TX holding register empty; byte accepted when tx_valid && tx_ready.
REQ-016 rx_overflow  out  1  one-cycle pulse: completed byte dropped, RX FIFO full.
REQ-017 tx_underrun  out  1  one-cycle pulse: frame byte loaded with fill 8'hFF, holding register empty.
REQ-018 busy  out  1  high while synchronized cs_n is low.

Function
REQ-019 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first; sclk frequency SHALL be at most clock/8.
REQ-020 SHALL pass sclk, cs_n, mosi through SYNC_STAGES flops, then one edge-detect register; edges detected only on synchronized values.
REQ-021 FSM states: IDLE, SHIFT. IDLE->SHIFT on synchronized cs_n fall; SHIFT->IDLE on synchronized cs_n rise.
REQ-022 On entry to SHIFT: load TX shift register from holding register (or 8'hFF with tx_underrun pulse), clear 3-bit bit counter, drive bit 7 on miso.
REQ-023 In SHIFT, each sclk rising edge SHALL shift synchronized mosi into the RX shift register and increment the bit counter modulo 8.
REQ-024 Each sclk falling edge SHALL shift the TX register left and drive the next bit; when bit counter is 0 (byte boundary), it SHALL instead load the next TX byte per REQ-022.
REQ-025 On the 8th rising edge, the completed byte SHALL be pushed into the RX FIFO; rx_valid asserts within SYNC_STAGES+2 clock cycles of the pin edge.
REQ-026 RX FIFO full at push: byte dropped, FIFO unchanged, rx_overflow pulses once.
REQ-027 Push and pop in the same cycle SHALL both take effect, including when full (no overflow) and when empty with push (byte visible next cycle).
REQ-028 cs_n rise mid-byte: partial RX bits discarded, no push, bit counter cleared; the loaded TX byte counts as consumed.
REQ-029 tx_ready SHALL rise the cycle after the holding register is moved into the shift register; a tx_valid accepted the same cycle as a load SHALL fill the holding register for the next byte.
REQ-030 miso_oe SHALL equal !synchronized cs_n; miso SHALL be 0 when miso_oe is low.
REQ-031 sclk edges while in IDLE SHALL be ignored.

Reset
REQ-032 On reset: FSM IDLE, FIFO empty, counters 0, holding register empty; outputs miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, rx_overflow=0, tx_underrun=0, busy=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release, the module SHALL wait for a fresh cs_n fall before shifting.

Configuration
REQ-034 Macro SPI_SLAVE_LSB_FIRST_EN: defined -> both directions shift LSB first (bit 0 driven first, first received bit lands in bit 0); undefined -> MSB first as in REQ-019..025.

Structure
REQ-035 Package spi_slave_pkg SHALL hold the state enum (IDLE, SHIFT), FRAME_BITS=8, and TX_FILL=8'hFF.
REQ-036 The RX FIFO SHALL be the sub-module spi_slave_rx_fifo (parameter RX_DEPTH, push/pop/full/empty).

Verification
REQ-037 Bench SHALL send 0xA5 with tx_data preloaded 0x3C -> rx_data=0xA5 popped once; master samples 0x3C on miso.
REQ-038 Bench SHALL send 5 bytes 0x01..0x05 with rx_ready=0, RX_DEPTH=4 -> FIFO holds 0x01..0x04; one rx_overflow pulse on 5th byte.
REQ-039 Bench SHALL run a frame with no tx_valid -> master reads 0xFF; tx_underrun pulses once at cs_n fall.
REQ-040 Bench SHALL raise cs_n after 5 bits, then send full byte 0x81 -> only 0x81 in FIFO, no partial byte.
REQ-041 Bench SHALL stream 2 bytes back-to-back with tx 0x11 then 0x22 supplied via handshake -> miso shows 0x11,0x22 without gap.
REQ-042 Bench SHALL assert reset after 3 bits of a frame -> all outputs at REQ-032 values next cycle; subsequent frame 0x5A received correctly.
